// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: input synchroniser, debounce filter, edge pulses
// and sticky write-1-to-clear pending flags feeding a single interrupt line.
module edge_event_unit #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     in_sig,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [DBNC_W-1:0]   dbnc,
    input  logic [N_CH-1:0]     clr_pend,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     rise_pulse,
    output logic [N_CH-1:0]     fall_pulse,
    output logic [N_CH-1:0]     pend,
    output logic                irq
);

    logic [N_CH-1:0]   s;
    logic [N_CH-1:0]   commit;
    logic [N_CH-1:0]   rise_en;
    logic [N_CH-1:0]   fall_en;
    logic [N_CH-1:0]   set_pend;
    logic [DBNC_W-1:0] cnt [N_CH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in_sig;
        end else begin : g_sync
            logic [N_CH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= in_sig;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A change commits once it has been seen on dbnc+1 consecutive edges; dbnc is read live.
    always_comb begin
        commit  = '0;
        rise_en = '0;
        fall_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            commit[i]  = (s[i] != level[i]) && (cnt[i] >= dbnc);
            rise_en[i] = mode[2*i];
            fall_en[i] = mode[2*i+1];
        end
    end

    assign set_pend = commit & ((s & rise_en) | (~s & fall_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            level      <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            pend       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] == level[i] || commit[i]) cnt[i] <= '0;
                else                               cnt[i] <= cnt[i] + DBNC_W'(1);
            end
            level      <= level ^ commit;
            rise_pulse <= commit & s;
            fall_pulse <= commit & ~s;
            // A new event in the same cycle as its clear strobe must not be lost.
            pend       <= set_pend | (pend & ~clr_pend);
        end
    end

    assign irq = |pend;

endmodule

// File: doc/edge_event_unit.md
# edge_event_unit

Multi-channel successor to the single-input edge highlighter: per-channel input synchronisation, programmable glitch filter (debounce), rising/falling edge pulses, per-channel edge-mode selection, and sticky pending flags with write-1-to-clear and an aggregated interrupt. Sits between raw external/async status lines and the register/interrupt fabric, replacing ad-hoc edge detectors on each line.

## Interface
- N_CH, 8, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input already synchronous, no sync flops)
- DBNC_W, 4, width of the debounce threshold

- clk  in  1  single clock; all state on posedge clk
- rst  in  1  asynchronous, active-high reset
- in_sig  in  N_CH  raw channel inputs
- mode  in  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- dbnc  in  DBNC_W  stable-cycle threshold; a change must persist dbnc+1 consecutive cycles
- clr_pend  in  N_CH  write-1-to-clear of pend, one-cycle strobe per bit
- level  out  N_CH  filtered (debounced) level per channel
- rise_pulse  out  N_CH  1-cycle pulse on filtered 0→1, independent of mode
- fall_pulse  out  N_CH  1-cycle pulse on filtered 1→0, independent of mode
- pend  out  N_CH  sticky event flag, set by mode-enabled edges
- irq  out  1  OR of pend

## Operation
- Per channel: sync chain (SYNC_STAGES flops) → `s`; filter state `level`; counter `cnt` (DBNC_W bits).
- Filter, each posedge:
  - s == level: cnt ← 0.
  - s != level and cnt ≥ dbnc: level ← s, cnt ← 0, fire the matching pulse.
  - s != level and cnt < dbnc: cnt ← cnt+1.
- dbnc sampled live every cycle; lowering it mid-count uses ≥, so commit happens on the next mismatching edge; cnt never exceeds 2^DBNC_W−1 (dbnc max bounds it).
- dbnc = 0: filter commits on the first mismatching edge (pure delay of one register).
- Glitch shorter than dbnc+1 cycles: cnt resets on return, no level change, no pulse.
- rise_pulse/fall_pulse registered, asserted for exactly the first cycle after level changes; never both on one channel in one cycle.
- pend[i] set when rise_pulse[i] with mode bit0, or fall_pulse[i] with mode bit1 (same cycle pulse is registered, i.e. pend rises together with the pulse).
- clr_pend[i] clears pend[i] on the next edge; simultaneous set and clear: set wins.
- Changing mode affects only future edges; setting mode to 00 does not clear pend.
- irq = |pend, combinational from registered pend (no extra latency).
- Channels fully independent; no arbitration.

## Timing
- Reset (async assert, sync behaviour on release): sync flops, level, cnt, rise_pulse, fall_pulse, pend all 0; irq 0.
- Reset mid-count or mid-pulse: all state cleared immediately; no pulse emitted on release from the aborted change.
- Input held 1 through reset release: treated as a 0→1 change; rise_pulse fires after normal latency.
- Latency: in_sig first sampled high at edge E0 → level, rise_pulse, pend updated at edge E0+SYNC_STAGES+dbnc; rise_pulse high for the one cycle after that edge.
- Minimum change spacing producing separate pulses: dbnc+1 cycles per level.

## Test plan
- Reset: rst=1 with in_sig=all 1s → all outputs 0; release, SYNC_STAGES=2, dbnc=0 → rise_pulse=all 1s for one cycle after edge E0+2, level=all 1s, pend per mode.
- Debounce: dbnc=3, ch0 high 3 cycles then low → no pulse, level stays 0; high 4 cycles → rise_pulse[0] after edge E0+5, one cycle wide.
- Modes: ch0..3 mode 00/01/10/11, drive 0→1→0 with stable spacing → pend = {ch1,ch3} after rise, {ch1,ch2,ch3} after fall; pulses appear on all four.
- Clear race: ch2 mode 11, assert clr_pend[2] in the same cycle its fall_pulse registers → pend[2] stays 1; clr_pend[2] next cycle → pend[2]=0, irq=0.
- dbnc change mid-count: dbnc=10, after cnt reaches 5 set dbnc=2 → level commits on the next edge.
- Reset mid-operation: assert rst while ch0 cnt=2 of dbnc=4 and pend=0xFF → all outputs 0 immediately; after release with in_sig=0, no pulses.
